// File: rtl/bsg_chip_io_link_packet_serializer.sv
// Packet-to-flit serializer feeding a chip IO link block.
// A whole packet (up to max_flits_p flits) is accepted in one handshake.
// Its flits 0..len are then streamed one per link handshake. When the last
// flit is accepted and another packet is already waiting, that packet is
// loaded in the same cycle, so no bubble appears between packets.
//
// Ports
//   core_clk_i        sole clock (rising edge)
//   core_reset_n_i    asynchronous active-low reset
//   v_i / ready_and_o packet handshake; data_i holds flit k at [k*W +: W]
//   len_i             flits in packet minus one
//   link_v_o / link_data_o / link_ready_and_i  flit handshake toward link
//   pkt_count_o       number of fully sent packets (wraps at 16 bits)
module bsg_chip_io_link_packet_serializer #(
  parameter  int link_width_p = 64,
  parameter  int max_flits_p  = 4,
  localparam int lg_flits_lp  = $clog2(max_flits_p)
) (
  input  logic                                 core_clk_i,
  input  logic                                 core_reset_n_i,
  input  logic                                 v_i,
  input  logic [link_width_p*max_flits_p-1:0]  data_i,
  input  logic [lg_flits_lp-1:0]               len_i,
  output logic                                 ready_and_o,
  output logic                                 link_v_o,
  output logic [link_width_p-1:0]              link_data_o,
  input  logic                                 link_ready_and_i,
  output logic [15:0]                          pkt_count_o
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                                     state_r, state_n;
  logic [max_flits_p-1:0][link_width_p-1:0]  data_r;
  logic [lg_flits_lp-1:0]                    len_r, cnt_r;
  logic [15:0]                               pkt_count_r;
  logic                                      last_hs;
  logic                                      load;

  always_comb begin
    state_n     = state_r;
    link_v_o    = 1'b0;
    link_data_o = '0;
    ready_and_o = 1'b0;
    last_hs     = 1'b0;
    case (state_r)
      IDLE: begin
        ready_and_o = core_reset_n_i;
        if (v_i) state_n = SEND;
      end
      SEND: begin
        // Valid never looks at ready, so the link sees a stable offer.
        link_v_o    = core_reset_n_i;
        link_data_o = data_r[cnt_r];
        last_hs     = link_ready_and_i && (cnt_r == len_r);
        // Only the cycle that frees the buffer may accept the next packet.
        ready_and_o = last_hs && core_reset_n_i;
        if (last_hs && !v_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign load        = v_i && ready_and_o;
  assign pkt_count_o = pkt_count_r;

  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      state_r     <= IDLE;
      data_r      <= '0;
      len_r       <= '0;
      cnt_r       <= '0;
      pkt_count_r <= '0;
    end else begin
      state_r <= state_n;
      if (load) begin
        data_r <= data_i;
        len_r  <= len_i;
        cnt_r  <= '0;
      end else if (state_r == SEND && link_ready_and_i && !last_hs) begin
        cnt_r <= cnt_r + 1'b1;
      end
      if (last_hs) pkt_count_r <= pkt_count_r + 16'd1;
    end
  end

endmodule

// File: tb/tb_bsg_chip_io_link_packet_serializer.sv
module tb_bsg_chip_io_link_packet_serializer;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          v;
  logic [255:0]  din;
  logic [1:0]    len;
  logic          ready;
  logic          link_v;
  logic [63:0]   link_data;
  logic          lr;
  logic [15:0]   pkt;

  int            checks = 0;
  int            failures = 0;
  logic [63:0]   exp_q[$];
  logic [15:0]   exp_pkt = 16'd0;
  int            rd = 0;

  // Output recorder: captures every handshaked flit and counts any cycle
  // where an unaccepted flit was withdrawn or changed.
  logic [63:0]   obs_mem [0:65535];
  int            obs_n = 0;
  int            viol = 0;
  logic          pv = 1'b0, phs = 1'b0;
  logic [63:0]   pd = '0;

  always #5 clk = ~clk;

  bsg_chip_io_link_packet_serializer dut (
    .core_clk_i       (clk),
    .core_reset_n_i   (rst_n),
    .v_i              (v),
    .data_i           (din),
    .len_i            (len),
    .ready_and_o      (ready),
    .link_v_o         (link_v),
    .link_data_o      (link_data),
    .link_ready_and_i (lr),
    .pkt_count_o      (pkt)
  );

  always @(negedge clk) begin
    if (!rst_n) begin
      pv  <= 1'b0;
      phs <= 1'b0;
    end else begin
      if (pv && !phs && (link_v !== 1'b1 || link_data !== pd)) viol <= viol + 1;
      if (link_v && lr) begin
        obs_mem[obs_n[15:0]] <= link_data;
        obs_n <= obs_n + 1;
      end
      pv  <= link_v;
      pd  <= link_data;
      phs <= link_v && lr;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] mk(input logic [63:0] a, b, c, e);
    return {e, c, b, a};
  endfunction

  task automatic push_exp(input logic [255:0] d, input int n);
    for (int k = 0; k <= n; k++) exp_q.push_back(d[k*64 +: 64]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v = 1'b0; lr = 1'b0; din = '0; len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", ready); end
    checks++; if (link_v !== 1'b0) begin failures++; $display("FAIL reset_link_v got=%b want=0", link_v); end
    checks++; if (link_data !== 64'd0) begin failures++; $display("FAIL reset_link_data got=%h want=0", link_data); end
    checks++; if (pkt !== 16'd0) begin failures++; $display("FAIL reset_pkt got=%0d want=0", pkt); end
    tick(); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b want=1", ready); end
    checks++; if (link_v !== 1'b0) begin failures++; $display("FAIL release_link_v got=%b want=0", link_v); end
  endtask

  task automatic test_basic();
    logic [255:0] d;
    logic [63:0]  got, e;
    d = mk(64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B,
           64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D);
    tick(); din = d; len = 2'd3; v = 1'b1; lr = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL basic_accept got=%b want=1", ready); end
    push_exp(d, 3); exp_pkt++;
    tick(); v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      checks++;
      if (link_v !== 1'b1 || link_data !== d[k*64 +: 64]) begin
        failures++;
        $display("FAIL basic_flit%0d got v=%b %h want v=1 %h", k, link_v, link_data, d[k*64 +: 64]);
      end
    end
    @(posedge clk); @(negedge clk);
    checks++; if (link_v !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b want=0", link_v); end
    checks++; if (pkt !== exp_pkt) begin failures++; $display("FAIL basic_pkt got=%0d want=%0d", pkt, exp_pkt); end
    while (rd < obs_n) begin
      got = obs_mem[rd[15:0]]; rd++; checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL basic_sb extra flit %h", got); end
      else begin e = exp_q.pop_front(); if (got !== e) begin failures++; $display("FAIL basic_sb got=%h want=%h", got, e); end end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL basic_sb missing=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] p, q;
    logic [63:0]  got, e;
    p = mk(64'h5000_0000_0000_0001, 64'h5100_0000_0000_0002, 64'hDEAD_0000_0000_0000, 64'hDEAD_0000_0000_0001);
    q = mk(64'h6000_0000_0000_0003, 64'hBEEF_0000_0000_0000, 64'hBEEF_0000_0000_0001, 64'hBEEF_0000_0000_0002);
    tick(); din = p; len = 2'd1; v = 1'b1; lr = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_accept_p got=%b want=1", ready); end
    push_exp(p, 1); exp_pkt++;
    tick(); din = q; len = 2'd0;
    @(negedge clk);
    checks++; if (ready !== 1'b0 || link_data !== p[63:0]) begin
      failures++; $display("FAIL b2b_p0 got ready=%b %h want ready=0 %h", ready, link_data, p[63:0]); end
    tick();
    @(negedge clk);
    checks++; if (ready !== 1'b1 || link_data !== p[127:64]) begin
      failures++; $display("FAIL b2b_p1 got ready=%b %h want ready=1 %h", ready, link_data, p[127:64]); end
    push_exp(q, 0); exp_pkt++;
    tick(); v = 1'b0;
    @(negedge clk);
    checks++; if (link_v !== 1'b1 || link_data !== q[63:0]) begin
      failures++; $display("FAIL b2b_q0 got v=%b %h want v=1 %h", link_v, link_data, q[63:0]); end
    tick();
    @(negedge clk);
    checks++; if (link_v !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b want=0", link_v); end
    checks++; if (pkt !== exp_pkt) begin failures++; $display("FAIL b2b_pkt got=%0d want=%0d", pkt, exp_pkt); end
    while (rd < obs_n) begin
      got = obs_mem[rd[15:0]]; rd++; checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_sb extra flit %h", got); end
      else begin e = exp_q.pop_front(); if (got !== e) begin failures++; $display("FAIL b2b_sb got=%h want=%h", got, e); end end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_sb missing=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_stall();
    logic [255:0] d;
    logic [63:0]  got, e;
    logic [3:0]   pat;
    int           hs, cyc, v0;
    pat = 4'b1001;
    d = mk(64'h7000_0000_0000_0000, 64'h7100_0000_0000_0001, 64'h7200_0000_0000_0002, 64'h7300_0000_0000_0003);
    tick(); din = d; len = 2'd3; v = 1'b1; lr = 1'b1;
    @(negedge clk);
    push_exp(d, 3); exp_pkt++; v0 = viol;
    hs = 0; cyc = 0;
    while (hs < 4 && cyc < 40) begin
      tick(); v = 1'b0; lr = pat[cyc % 4]; cyc++;
      @(negedge clk);
      if (link_v && lr) hs++;
    end
    checks++; if (hs !== 4) begin failures++; $display("FAIL stall_handshakes got=%0d want=4", hs); end
    tick(); lr = 1'b1;
    @(negedge clk);
    checks++; if (link_v !== 1'b0) begin failures++; $display("FAIL stall_idle got=%b want=0", link_v); end
    checks++; if (viol !== v0) begin failures++; $display("FAIL stall_stable got=%0d want=%0d", viol, v0); end
    checks++; if (pkt !== exp_pkt) begin failures++; $display("FAIL stall_pkt got=%0d want=%0d", pkt, exp_pkt); end
    while (rd < obs_n) begin
      got = obs_mem[rd[15:0]]; rd++; checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL stall_sb extra flit %h", got); end
      else begin e = exp_q.pop_front(); if (got !== e) begin failures++; $display("FAIL stall_sb got=%h want=%h", got, e); end end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stall_sb missing=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] d, d2;
    logic [63:0]  got, e;
    d  = mk(64'h8000_0000_0000_0000, 64'h8100_0000_0000_0001, 64'h8200_0000_0000_0002, 64'h8300_0000_0000_0003);
    d2 = mk(64'h9000_0000_0000_0000, 64'h9100_0000_0000_0001, 64'h9200_0000_0000_0002, 64'h9300_0000_0000_0003);
    tick(); din = d; len = 2'd3; v = 1'b1; lr = 1'b1;
    @(negedge clk);
    push_exp(d, 3);
    tick(); v = 1'b0;
    @(posedge clk);        // flit 0 consumed
    @(posedge clk);        // flit 1 consumed
    #1 rst_n = 1'b0;
    #1;
    checks++; if (link_v !== 1'b0) begin failures++; $display("FAIL rstmid_link_v got=%b want=0", link_v); end
    checks++; if (pkt !== 16'd0) begin failures++; $display("FAIL rstmid_pkt got=%0d want=0", pkt); end
    exp_pkt = 16'd0;
    @(negedge clk);
    while (rd < obs_n) begin
      got = obs_mem[rd[15:0]]; rd++; checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL rstmid_sb extra flit %h", got); end
      else begin e = exp_q.pop_front(); if (got !== e) begin failures++; $display("FAIL rstmid_sb got=%h want=%h", got, e); end end
    end
    checks++; if (exp_q.size() != 2) begin failures++; $display("FAIL rstmid_discard remaining=%0d want=2", exp_q.size()); end
    exp_q.delete();
    checks++; if (ready !== 1'b0 || link_v !== 1'b0) begin
      failures++; $display("FAIL rstmid_held got ready=%b v=%b want 0 0", ready, link_v); end
    tick(); rst_n = 1'b1;
    tick(); din = d2; len = 2'd1; v = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rstmid_accept got=%b want=1", ready); end
    push_exp(d2, 1); exp_pkt++;
    tick(); v = 1'b0;
    @(negedge clk);
    checks++; if (link_v !== 1'b1 || link_data !== d2[63:0]) begin
      failures++; $display("FAIL rstmid_first got v=%b %h want v=1 %h", link_v, link_data, d2[63:0]); end
    tick(); tick();
    @(negedge clk);
    checks++; if (link_v !== 1'b0 || pkt !== exp_pkt) begin
      failures++; $display("FAIL rstmid_done got v=%b pkt=%0d want v=0 pkt=%0d", link_v, pkt, exp_pkt); end
    while (rd < obs_n) begin
      got = obs_mem[rd[15:0]]; rd++; checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL rstmid_sb2 extra flit %h", got); end
      else begin e = exp_q.pop_front(); if (got !== e) begin failures++; $display("FAIL rstmid_sb2 got=%h want=%h", got, e); end end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rstmid_sb2 missing=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_random(input int n);
    logic [63:0] got, e;
    int acc, cyc, v0, w;
    logic pend;
    acc = 0; cyc = 0; pend = 1'b0; v0 = viol;
    while (acc < n && cyc < 30000) begin
      tick(); cyc++;
      if (!pend && $urandom_range(0, 9) < 6) begin
        pend = 1'b1;
        for (int k = 0; k < 8; k++) din[k*32 +: 32] = $urandom;
        len = 2'($urandom_range(0, 3));
      end
      v  = pend;
      lr = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (v && ready) begin
        push_exp(din, int'(len)); exp_pkt++; acc++; pend = 1'b0;
      end
    end
    checks++; if (acc != n) begin failures++; $display("FAIL rand_timeout accepted=%0d want=%0d", acc, n); end
    tick(); v = 1'b0; lr = 1'b1;
    w = 0;
    @(negedge clk);
    while (link_v && w < 10) begin @(negedge clk); w++; end
    checks++; if (link_v !== 1'b0) begin failures++; $display("FAIL rand_drain got=%b want=0", link_v); end
    checks++; if (pkt !== exp_pkt) begin failures++; $display("FAIL rand_pkt got=%0d want=%0d", pkt, exp_pkt); end
    checks++; if (viol !== v0) begin failures++; $display("FAIL rand_stable got=%0d want=%0d", viol, v0); end
    @(negedge clk);
    while (rd < obs_n) begin
      got = obs_mem[rd[15:0]]; rd++; checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL rand_sb extra flit %h", got); end
      else begin e = exp_q.pop_front(); if (got !== e) begin failures++; $display("FAIL rand_sb got=%h want=%h", got, e); end end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_sb missing=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    logic [63:0] got, e;
    int target, acc, cyc;
    target = 65535 - int'(exp_pkt);
    acc = 0; cyc = 0; lr = 1'b1; len = 2'd0;
    while (acc < target && cyc < 70000) begin
      tick(); cyc++;
      v = 1'b1;
      din[63:0] = 64'hA5A5_0000_0000_0000 ^ 64'(acc);
      @(negedge clk);
      if (ready) begin push_exp(din, 0); exp_pkt++; acc++; end
      while (rd < obs_n) begin
        got = obs_mem[rd[15:0]]; rd++; checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL wrap_sb extra flit %h", got); end
        else begin e = exp_q.pop_front(); if (got !== e) begin failures++; $display("FAIL wrap_sb got=%h want=%h", got, e); end end
      end
    end
    checks++; if (acc != target) begin failures++; $display("FAIL wrap_timeout accepted=%0d want=%0d", acc, target); end
    tick(); v = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++; if (pkt !== 16'hFFFF) begin failures++; $display("FAIL wrap_max got=%h want=ffff", pkt); end
    tick(); v = 1'b1; din[63:0] = 64'hFACE_0000_0000_0001;
    @(negedge clk);
    push_exp(din, 0); exp_pkt++;
    tick(); v = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (pkt !== 16'h0000 || link_v !== 1'b0) begin
      failures++; $display("FAIL wrap_zero got pkt=%h v=%b want pkt=0000 v=0", pkt, link_v); end
    while (rd < obs_n) begin
      got = obs_mem[rd[15:0]]; rd++; checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL wrap_sb2 extra flit %h", got); end
      else begin e = exp_q.pop_front(); if (got !== e) begin failures++; $display("FAIL wrap_sb2 got=%h want=%h", got, e); end end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_sb2 missing=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random(1000);
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
